// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
// Multiplies take one working cycle; divides run a restoring shift-subtract
// loop of XLEN iterations followed by a sign-fixup cycle. Division by zero
// and signed overflow bypass the loop and go straight to DONE.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   flush_i        synchronous kill of any in-flight or held operation
//   in_valid_i     request present
//   in_ready_o     unit can accept a request
//   op_i           0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   data_in_a_i    rs1 (dividend / multiplicand)
//   data_in_b_i    rs2 (divisor / multiplier)
//   tag_in_i       destination tag
//   out_valid_o    result present
//   out_ready_i    consumer takes result
//   data_out_o     result
//   tag_out_o      tag of the operation that produced data_out_o
//   busy_o         unit not idle
//
// state | meaning
// IDLE  | waiting for a request
// MUL   | forming the 2*XLEN product
// DIV   | restoring division iterations on magnitudes
// FIX   | applying signs, selecting quotient or remainder
// DONE  | result held until consumed

module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int OP_SIZE = 3,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [OP_SIZE-1:0] op_i,
    input  logic [XLEN-1:0]    data_in_a_i,
    input  logic [XLEN-1:0]    data_in_b_i,
    input  logic [TAG_W-1:0]   tag_in_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    data_out_o,
    output logic [TAG_W-1:0]   tag_out_o,
    output logic               busy_o
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [OP_SIZE-1:0] op_q, op_d;
    logic [XLEN-1:0]    a_q, a_d;      // multiplicand, or dividend magnitude shifting into quotient
    logic [XLEN-1:0]    b_q, b_d;      // multiplier, or divisor magnitude
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sa_q, sa_d;    // dividend negative (signed ops only)
    logic               sb_q, sb_d;    // divisor negative (signed ops only)

    logic               accept;
    logic               div_signed;
    logic               in_a_neg;
    logic               in_b_neg;
    logic               div_zero;
    logic               div_ovf;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               mul_a_sgn;
    logic               mul_b_sgn;
    logic [2*XLEN-1:0]  a_ext;
    logic [2*XLEN-1:0]  b_ext;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN:0]      shifted;
    logic [XLEN:0]      diff;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;

    assign in_ready_o  = (state_q == ST_IDLE) && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign data_out_o  = res_q;
    assign tag_out_o   = tag_q;

    // Division operand preparation straight from the request inputs.
    assign div_signed = !op_i[0];
    assign in_a_neg   = div_signed && data_in_a_i[XLEN-1];
    assign in_b_neg   = div_signed && data_in_b_i[XLEN-1];
    assign a_mag      = in_a_neg ? -data_in_a_i : data_in_a_i;
    assign b_mag      = in_b_neg ? -data_in_b_i : data_in_b_i;
    assign div_zero   = (data_in_b_i == '0);
    assign div_ovf    = div_signed
                        && (data_in_a_i == {1'b1, {(XLEN-1){1'b0}}})
                        && (data_in_b_i == '1);

    // MULH and MULHSU treat a as signed; only MULH treats b as signed.
    // MUL uses the low half, which is identical for any extension.
    assign mul_a_sgn = (op_q[1:0] == 2'd1) || (op_q[1:0] == 2'd2);
    assign mul_b_sgn = (op_q[1:0] == 2'd1);
    assign a_ext     = {{XLEN{mul_a_sgn && a_q[XLEN-1]}}, a_q};
    assign b_ext     = {{XLEN{mul_b_sgn && b_q[XLEN-1]}}, b_q};
    assign prod      = a_ext * b_ext;

    // Partial remainder is always below the divisor, so one extra bit
    // holds the shifted value and the borrow of the trial subtract.
    assign shifted = {rem_q, a_q[XLEN-1]};
    assign diff    = shifted - {1'b0, b_q};

    assign quo_fix = (sa_q ^ sb_q) ? -a_q : a_q;
    assign rem_fix = sa_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        res_d   = res_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op_i;
                    tag_d = tag_in_i;
                    if (!op_i[2]) begin
                        a_d     = data_in_a_i;
                        b_d     = data_in_b_i;
                        state_d = ST_MUL;
                    end else if (div_zero) begin
                        res_d   = op_i[1] ? data_in_a_i : '1;
                        state_d = ST_DONE;
                    end else if (div_ovf) begin
                        res_d   = op_i[1] ? '0 : data_in_a_i;
                        state_d = ST_DONE;
                    end else begin
                        a_d     = a_mag;
                        b_d     = b_mag;
                        rem_d   = '0;
                        sa_d    = in_a_neg;
                        sb_d    = in_b_neg;
                        cnt_d   = CW'(XLEN);
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                res_d   = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                state_d = ST_DONE;
            end
            ST_DIV: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                res_d   = op_q[1] ? rem_fix : quo_fix;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Drives an XLEN=32 and an XLEN=64 instance of muldiv_unit with directed
// and random operations and compares results, tags and latency against an
// arithmetic reference model.

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        iv32 = 1'b0;
    logic        iv64 = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  op_s = '0;
    logic [63:0] a_s = '0;
    logic [63:0] b_s = '0;
    logic [4:0]  tag_s = '0;
    logic        sel64 = 1'b0;

    logic        rdy32, ov32, busy32;
    logic [31:0] d32;
    logic [4:0]  t32;
    logic        rdy64, ov64, busy64;
    logic [63:0] d64;
    logic [4:0]  t64;

    logic        rdy_m, ov_m, busy_m;
    logic [63:0] d_m;
    logic [4:0]  t_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .OP_SIZE(3), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(iv32), .in_ready_o(rdy32), .op_i(op_s),
        .data_in_a_i(a_s[31:0]), .data_in_b_i(b_s[31:0]), .tag_in_i(tag_s),
        .out_valid_o(ov32), .out_ready_i(out_ready),
        .data_out_o(d32), .tag_out_o(t32), .busy_o(busy32)
    );

    muldiv_unit #(.XLEN(64), .OP_SIZE(3), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(iv64), .in_ready_o(rdy64), .op_i(op_s),
        .data_in_a_i(a_s), .data_in_b_i(b_s), .tag_in_i(tag_s),
        .out_valid_o(ov64), .out_ready_i(out_ready),
        .data_out_o(d64), .tag_out_o(t64), .busy_o(busy64)
    );

    assign rdy_m  = sel64 ? rdy64 : rdy32;
    assign ov_m   = sel64 ? ov64 : ov32;
    assign busy_m = sel64 ? busy64 : busy32;
    assign d_m    = sel64 ? d64 : {32'b0, d32};
    assign t_m    = sel64 ? t64 : t32;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int w, input logic [63:0] x);
        return (w == 32) ? {32'b0, x[31:0]} : x;
    endfunction

    function automatic bit is_special(input int w, input logic [2:0] op,
                                      input logic [63:0] a, input logic [63:0] b);
        logic [63:0] am, bm, minv;
        am   = msk(w, a);
        bm   = msk(w, b);
        minv = msk(w, 64'h1 << (w - 1));
        if (!op[2]) return 1'b0;
        if (bm == '0) return 1'b1;
        return (!op[0] && am == minv && bm == msk(w, '1));
    endfunction

    // Plain wide signed/unsigned arithmetic; SV division truncates toward zero
    // and the remainder takes the dividend's sign, as RISC-V requires.
    function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] as_, bs_, au_, bu_, p, r;
        logic [63:0] am, bm;
        am  = msk(w, a);
        bm  = msk(w, b);
        au_ = $signed({66'b0, am});
        bu_ = $signed({66'b0, bm});
        if (w == 32) begin
            as_ = $signed(am[31:0]);
            bs_ = $signed(bm[31:0]);
        end else begin
            as_ = $signed(am);
            bs_ = $signed(bm);
        end
        case (op)
            3'd0: begin p = as_ * bs_; return msk(w, p[63:0]); end
            3'd1: begin p = as_ * bs_; r = p >>> w; return msk(w, r[63:0]); end
            3'd2: begin p = as_ * bu_; r = p >>> w; return msk(w, r[63:0]); end
            3'd3: begin p = au_ * bu_; r = p >>> w; return msk(w, r[63:0]); end
            default: begin
                if (bm == '0) return op[1] ? am : msk(w, '1);
                if (is_special(w, op, a, b)) return op[1] ? 64'd0 : am;
                case (op)
                    3'd4:    r = as_ / bs_;
                    3'd5:    r = au_ / bu_;
                    3'd6:    r = as_ % bs_;
                    default: r = au_ % bu_;
                endcase
                return msk(w, r[63:0]);
            end
        endcase
    endfunction

    // Issues one request, waits for the result and checks value, tag and
    // latency. Leaves the result held when out_ready is low.
    task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag, input string nm);
        logic [63:0] exp;
        int explat, cyc;
        exp    = ref_model(w, op, a, b);
        explat = !op[2] ? 2 : (is_special(w, op, a, b) ? 1 : w + 2);
        @(negedge clk);
        sel64 = (w == 64);
        #1;
        chk({nm, "_in_ready"}, 64'(rdy_m), 64'd1);
        op_s  = op;
        a_s   = msk(w, a);
        b_s   = msk(w, b);
        tag_s = tag;
        if (w == 32) iv32 = 1'b1; else iv64 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        iv64 = 1'b0;
        cyc  = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (ov_m) break;
            cyc++;
        end
        if (cyc >= 200) begin
            chk({nm, "_timeout"}, 64'd1, 64'd0);
        end else begin
            chk({nm, "_latency"}, 64'(cyc + 1), 64'(explat));
            chk({nm, "_data"}, d_m, exp);
            chk({nm, "_tag"}, 64'(t_m), 64'(tag));
        end
    endtask

    task automatic directed(input int w);
        logic [63:0] m1, minv;
        m1   = msk(w, '1);
        minv = msk(w, 64'h1 << (w - 1));
        run_op(w, 3'd0, 64'd7, msk(w, -64'd3), 5'd3, "mul_7_m3");
        run_op(w, 3'd3, m1, m1, 5'd4, "mulhu_m1");
        run_op(w, 3'd1, m1, m1, 5'd5, "mulh_m1");
        run_op(w, 3'd2, m1, m1, 5'd6, "mulhsu_m1");
        run_op(w, 3'd4, msk(w, -64'd7), 64'd2, 5'd7, "div_m7_2");
        run_op(w, 3'd6, msk(w, -64'd7), 64'd2, 5'd8, "rem_m7_2");
        run_op(w, 3'd5, 64'd100, 64'd7, 5'd9, "divu_100_7");
        run_op(w, 3'd7, 64'd100, 64'd7, 5'd10, "remu_100_7");
        run_op(w, 3'd5, 64'd5, 64'd0, 5'd11, "divu_by0");
        run_op(w, 3'd6, 64'd5, 64'd0, 5'd12, "rem_by0");
        run_op(w, 3'd4, minv, m1, 5'd13, "div_ovf");
        run_op(w, 3'd6, minv, m1, 5'd14, "rem_ovf");
        run_op(w, 3'd4, 64'd20, msk(w, -64'd6), 5'd15, "div_20_m6");
        run_op(w, 3'd6, msk(w, -64'd20), msk(w, -64'd6), 5'd16, "rem_m20_m6");
    endtask

    task automatic random_ops(input int w, input int n);
        logic [63:0] a, b;
        logic [2:0]  op;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 15))
                0: b = '0;
                1: begin a = 64'h1 << (w - 1); b = '1; end
                2: b = 64'($urandom_range(1, 9));
                3: a = 64'($urandom_range(0, 50));
                default: ;
            endcase
            run_op(w, op, a, b, 5'($urandom), "rand");
        end
    endtask

    initial begin : main
        logic [31:0] held_d;
        logic [4:0]  held_t;
        bit          seen;

        #12;
        chk("rst_rdy32", 64'(rdy32), 64'd1);
        chk("rst_ov32", 64'(ov32), 64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_data32", 64'(d32), 64'd0);
        chk("rst_tag32", 64'(t32), 64'd0);
        chk("rst_data64", d64, 64'd0);
        chk("rst_busy64", 64'(busy64), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed(32);
        directed(64);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        run_op(32, 3'd0, 64'd6, 64'd9, 5'd21, "bp_mul");
        held_d = d32;
        held_t = t32;
        op_s   = 3'd0;
        a_s    = 64'd2;
        b_s    = 64'd2;
        tag_s  = 5'd1;
        iv32   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(ov32), 64'd1);
            chk("bp_data", 64'(d32), 64'(held_d));
            chk("bp_tag", 64'(t32), 64'(held_t));
            chk("bp_in_ready", 64'(rdy32), 64'd0);
        end
        chk("bp_value", 64'(held_d), 64'd54);
        iv32      = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 64'(rdy32), 64'd1);
        chk("bp_release_ov", 64'(ov32), 64'd0);

        // Flush during the division loop.
        op_s  = 3'd4;
        a_s   = 64'd1000;
        b_s   = 64'd7;
        tag_s = 5'd2;
        iv32  = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("fl_busy_before", 64'(busy32), 64'd1);
        flush = 1'b1;
        op_s  = 3'd0;
        iv32  = 1'b1;
        #1;
        chk("fl_in_ready_low", 64'(rdy32), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        iv32  = 1'b0;
        @(negedge clk);
        chk("fl_busy_after", 64'(busy32), 64'd0);
        chk("fl_rdy_after", 64'(rdy32), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | ov32;
        end
        chk("fl_no_valid", 64'(seen), 64'd0);
        run_op(32, 3'd0, 64'd3, 64'd4, 5'd17, "fl_mul_3_4");

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        op_s  = 3'd5;
        a_s   = 64'd1000;
        b_s   = 64'd7;
        tag_s = 5'd30;
        iv32  = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 64'(busy32), 64'd0);
        chk("ar_ov", 64'(ov32), 64'd0);
        chk("ar_rdy", 64'(rdy32), 64'd1);
        chk("ar_data", 64'(d32), 64'd0);
        chk("ar_tag", 64'(t32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32, 3'd5, 64'd9, 64'd3, 5'd19, "ar_divu_9_3");
        run_op(64, 3'd5, 64'd9, 64'd3, 5'd20, "ar_divu_9_3_64");

        random_ops(32, 120);
        random_ops(64, 120);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
